shifter_pipe: RTL and testbench
===============================

# shifter_pipe

Parametrised, pipelined barrel shifter: the successor to the combinational SLL-only shifter in the ALU datapath. Supports logical left, logical right, arithmetic right and (optionally) rotate-right over a configurable word width. Operands enter through a valid/ready handshake and results leave through one, with two register stages and full backpressure. It sits between the ALU operand muxes and the ALU result mux.

## Interface
- `WIDTH`, default 32: operand/result width.
  - Must be a power of two, ≥ 8.
  - `SHW = log2(WIDTH)` is derived internally.
- `clk`: input, 1 bit, the only clock; all state updates on its rising edge.
- `reset`: input, 1 bit, asynchronous, active-low. Low clears all state immediately.
- `in_valid`: input, 1 bit, operands and opcode present.
- `in_ready`: output, 1 bit, stage 1 can accept this cycle.
- `dataA`: input, `WIDTH` bits, value to shift.
- `dataB`: input, `WIDTH` bits, shift amount.
  - Only `dataB[SHW-1:0]` is used; upper bits are ignored.
- `Signal`: input, 6 bits, opcode.
- `out_valid`: output, 1 bit, result present.
- `out_ready`: input, 1 bit, downstream accepts the result.
- `dataOut`: output, `WIDTH` bits, shifted result.
- `err`: output, 1 bit, the opcode of the presented result was unsupported. Qualified by `out_valid`.

## Operation
Opcodes:
- SLL = 6'b000000
- SRL = 6'b000010
- SRA = 6'b000011
- ROTR = 6'b000110 (only with `SHIFTER_ROT_EN`)

Any other opcode produces `dataOut = 0` and `err = 1`. It still flows through the pipeline and handshakes normally.

Per-mode behaviour, with shift amount `sh = dataB[SHW-1:0]`:
- SLL: zero fill from the LSB.
- SRL: zero fill from the MSB.
- SRA: the MSB is replicated.
- ROTR: bits shifted out at the LSB re-enter at the MSB.
- `sh = 0` passes `dataA` through unchanged in all modes.

Datapath:
- The shift is built as `SHW` log-stages; stage k shifts by 2^k when `sh[k]` is set.
- Right shifts and rotate use the same right-shift network. Its fill bit is 0 for SRL, `dataA[WIDTH-1]` for SRA, and the wrapped bits for ROTR.
- SLL may be built by bit-reversal around the right network, or with a separate left network. Either is acceptable.

Pipeline:
- Stage 1 register: captures `dataA`, `sh`, the decoded mode and `err`.
- Stage 2 register: the full shift network sits between stage 1 and stage 2. Stage 2 holds `dataOut`, `err` and `out_valid`.
- Each stage has a valid bit, v1 and v2.

Handshake:
- `ready2 = !v2 || out_ready`
- `in_ready = !v1 || ready2`, combinational.
- Transfer into a stage occurs when its upstream valid and its own ready are both high in the same cycle.
- With `in_valid` and `out_ready` continuously high, one result is produced per cycle.
- While `out_valid && !out_ready`, `dataOut` and `err` hold stable.
- `out_valid` never drops without an accepting handshake.
- Inputs are sampled only on a transfer. Changes to `dataA`, `dataB` or `Signal` while `in_ready` is low have no effect.

## Timing
- Latency is 2 cycles. A transfer at edge N presents the result with `out_valid = 1` after edge N+1, so it can be consumed at edge N+2.
- Reset state: v1 = 0, v2 = 0, `out_valid` = 0, `dataOut` = 0, `err` = 0, stage 1 register = 0.
  - `in_ready` = 1 while `reset` is low and on the first cycle after it.
- Reset asserted mid-operation discards all in-flight operations. No partial result is ever presented.
- Full pipeline (v1 = v2 = 1) with `out_ready = 0`: `in_ready = 0`.
  - In the cycle `out_ready` rises, stage 2 unloads, stage 1 advances and a new input is accepted. All three happen in that one cycle.
- Simultaneous unload of stage 2 and load from stage 1 is a normal transfer. It produces no bubble and no duplicate.
- Empty pipeline: `out_valid = 0`. `dataOut` holds its last value; its content is don't-care and nothing checks it.

## Configuration
- Macro `SHIFTER_ROT_EN`.
- Defined: ROTR (6'b000110) is supported as above.
- Undefined:
  - No rotate logic is built; the fill is 0 or the sign bit only.
  - 6'b000110 is an unsupported opcode and gives `dataOut = 0`, `err = 1`.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use `WIDTH = 32` unless stated.

1. Reset and basic SLL:
   - Assert `reset` low for 3 cycles: `out_valid = 0`, `dataOut = 0`, `in_ready = 1`.
   - Release reset, then send SLL with `dataA = 0x0000_0001`, `dataB = 31`.
   - Required: `dataOut = 0x8000_0000` after 2 cycles, `err = 0`.
2. Right shifts and amount masking:
   - SRA with `dataA = 0x8000_00F0`, `dataB = 4`: `dataOut = 0xF800_000F`.
   - SRL with the same operands: `dataOut = 0x0800_000F`.
   - `dataB = 0x24`, which uses `sh = 4`: results identical to `dataB = 4`.
3. Rotate and unsupported opcode:
   - With `SHIFTER_ROT_EN` defined: ROTR `0x0000_00F1` by 4 gives `0x1000_000F`, `err = 0`.
   - With the macro undefined: the same input gives `dataOut = 0`, `err = 1`.
   - `Signal = 6'b111111`: `dataOut = 0`, `err = 1` in either build.
4. Backpressure:
   - Stream 4 SLL operations, `dataA = 1`, `dataB = 0..3`, with `out_ready` low for cycles 2–5.
   - Required: `in_ready` falls once 2 operations are held, `dataOut` is stable while stalled, and the results arrive in order 1, 2, 4, 8 with no loss or duplication.
5. Full throughput:
   - 16 back-to-back random operations with `in_valid` and `out_ready` held high.
   - Required: 16 consecutive `out_valid` cycles, each result matching the reference model.
6. Mid-flight reset and width:
   - Pull `reset` low while v1 = v2 = 1: `out_valid` drops to 0 immediately and stays 0 until new input arrives.
   - Repeat scenarios 1–2 with `WIDTH = 8`, e.g. SRA `0x90` by 3 gives `0xF2`.

Source files
------------

// File: rtl/shifter_pipe.sv
// -----------------------------------------------------------------------------
// shifter_pipe
//
// Two-stage pipelined barrel shifter for the ALU datapath. It sits between the
// ALU operand muxes and the ALU result mux.
//
// Supported operations (opcode on Signal):
//   SLL  6'b000000  logical left, zero fill from the LSB
//   SRL  6'b000010  logical right, zero fill from the MSB
//   SRA  6'b000011  arithmetic right, MSB replicated
//   ROTR 6'b000110  rotate right (only when SHIFTER_ROT_EN is defined)
// Any other opcode yields dataOut = 0 with err = 1. Such an operation still
// travels through the pipeline and handshakes like any other.
//
// Build option:
//   `define SHIFTER_ROT_EN  builds the rotate path and accepts ROTR. Without
//                           it, no wrap logic exists and ROTR is unsupported.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low; clears all state
//   in_valid   operand/opcode present
//   in_ready   stage 1 can accept this cycle
//   dataA      value to shift (WIDTH bits)
//   dataB      shift amount; only dataB[SHW-1:0] is used
//   Signal     6-bit opcode
//   out_valid  result present
//   out_ready  downstream accepts the result
//   dataOut    shifted result (WIDTH bits)
//   err        presented result had an unsupported opcode (qualified by out_valid)
//
// Parameter:
//   WIDTH      operand width, a power of two and at least 8. SHW = log2(WIDTH).
//
// Latency is two cycles: a transfer at edge N shows out_valid after edge N+1.
// -----------------------------------------------------------------------------
module shifter_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataOut,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  if ((WIDTH < 8) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_width_check
    $error("shifter_pipe: WIDTH must be a power of two and at least 8");
  end

  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;
`ifdef SHIFTER_ROT_EN
  localparam logic [5:0] OP_ROTR = 6'b000110;
`endif

  typedef enum logic [1:0] {
    MODE_SLL  = 2'd0,
    MODE_SRL  = 2'd1,
    MODE_SRA  = 2'd2,
    MODE_ROTR = 2'd3
  } mode_t;

  // ---------------------------------------------------------------------------
  // Input side: opcode decode and handshake
  // ---------------------------------------------------------------------------
  mode_t           mode_d;
  logic            err_d;
  logic [SHW-1:0]  sh_d;
  logic            unused_b;

  // The upper shift-amount bits are deliberately ignored.
  assign unused_b = ^dataB[WIDTH-1:SHW];
  assign sh_d     = dataB[SHW-1:0];

  always_comb begin
    mode_d = MODE_SLL;
    err_d  = 1'b0;
    case (Signal)
      OP_SLL:  mode_d = MODE_SLL;
      OP_SRL:  mode_d = MODE_SRL;
      OP_SRA:  mode_d = MODE_SRA;
`ifdef SHIFTER_ROT_EN
      OP_ROTR: mode_d = MODE_ROTR;
`endif
      default: err_d  = 1'b1;
    endcase
  end

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [SHW-1:0]   sh_p1;
  mode_t            mode_p1;
  logic             err_p1;

  logic             vld_p2;
  logic [WIDTH-1:0] dout_p2;
  logic             err_p2;

  logic             ready_p2;
  logic             load_p1;
  logic             load_p2;

  // Stage 2 frees up when it is empty or being drained this cycle; stage 1
  // frees up when it is empty or can hand its contents to stage 2. This lets
  // unload, advance and accept all happen on the same edge.
  assign ready_p2 = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || ready_p2;
  assign load_p1  = in_valid && in_ready;
  assign load_p2  = vld_p1 && ready_p2;

  // ---------------------------------------------------------------------------
  // Stage 1 register: operand, shift amount, decoded mode, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_p1    <= '0;
      sh_p1   <= '0;
      mode_p1 <= MODE_SLL;
      err_p1  <= 1'b0;
    end else if (load_p1) begin
      a_p1    <= dataA;
      sh_p1   <= sh_d;
      mode_p1 <= mode_d;
      err_p1  <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift network between stage 1 and stage 2
  // ---------------------------------------------------------------------------
  // One right-shift network serves every mode. SLL is done by reversing the
  // bit order on the way in and on the way out, so a right shift with zero
  // fill becomes a left shift with zero fill.
  logic             rev_sel;
  logic             fill;
  logic [WIDTH-1:0] a_rev;
  logic [WIDTH-1:0] net_in;
  logic [WIDTH-1:0] net_out;
  logic [WIDTH-1:0] net_rev;
  logic [WIDTH-1:0] shift_res;
`ifdef SHIFTER_ROT_EN
  logic             rot;
  assign rot = (mode_p1 == MODE_ROTR);
`endif

  assign rev_sel = (mode_p1 == MODE_SLL);
  assign fill    = (mode_p1 == MODE_SRA) && a_p1[WIDTH-1];
  assign a_rev   = {<<{a_p1}};
  assign net_in  = rev_sel ? a_rev : a_p1;

  // Log-stage k moves the word right by 2^k when sh_p1[k] is set. The bits
  // entering at the top are either the fill bit or, for rotate, the bits that
  // just left at the bottom.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int D = 1 << k;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] dst;
    logic [D-1:0]     wrap;

    if (k == 0) begin : g_first
      assign src = net_in;
    end else begin : g_next
      assign src = g_stage[k-1].dst;
    end

`ifdef SHIFTER_ROT_EN
    assign wrap = rot ? src[D-1:0] : {D{fill}};
`else
    assign wrap = {D{fill}};
`endif

    assign dst = sh_p1[k] ? {wrap, src[WIDTH-1:D]} : src;
  end

  assign net_out   = g_stage[SHW-1].dst;
  assign net_rev   = {<<{net_out}};
  assign shift_res = rev_sel ? net_rev : net_out;

  // ---------------------------------------------------------------------------
  // Stage 2 register: result, error flag, output valid
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p2 <= 1'b0;
    end else if (ready_p2) begin
      vld_p2 <= vld_p1;
    end
  end

  // Loading only on a transfer keeps dataOut/err frozen while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_p2 <= '0;
      err_p2  <= 1'b0;
    end else if (load_p2) begin
      dout_p2 <= err_p1 ? '0 : shift_res;
      err_p2  <= err_p1;
    end
  end

  assign out_valid = vld_p2;
  assign dataOut   = dout_p2;
  assign err       = err_p2;

endmodule

// File: tb/tb_shifter_pipe.sv
// -----------------------------------------------------------------------------
// tb_shifter_pipe
//
// Self-checking bench for shifter_pipe. A reference model computes each result
// from the opcode rules with plain shift operators; a scoreboard queue pairs
// every accepted input with the result that must later leave the pipeline.
// Directed sequences pin reset, latency, backpressure, throughput, mid-flight
// reset and an 8-bit instance with literal expectations.
// -----------------------------------------------------------------------------
module tb_shifter_pipe;

  localparam logic [5:0] SLL  = 6'b000000;
  localparam logic [5:0] SRL  = 6'b000010;
  localparam logic [5:0] SRA  = 6'b000011;
  localparam logic [5:0] ROTR = 6'b000110;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] dataOut;
  logic        err;

  // 8-bit instance
  logic        iv8 = 1'b0;
  logic        ir8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [5:0]  s8 = '0;
  logic        ov8;
  logic        or8 = 1'b1;
  logic [7:0]  d8;
  logic        e8;

  shifter_pipe #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .out_valid(out_valid), .out_ready(out_ready),
    .dataOut(dataOut), .err(err)
  );

  shifter_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(iv8), .in_ready(ir8),
    .dataA(a8), .dataB(b8), .Signal(s8),
    .out_valid(ov8), .out_ready(or8),
    .dataOut(d8), .err(e8)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [32:0] exp_q[$];
  logic [31:0] got_q[$];
  logic        stall_prev = 1'b0;
  logic [31:0] held_d = '0;
  logic        held_e = 1'b0;
  int          ov_run = 0;
  int          ov_best = 0;
  logic        saw_block = 1'b0;
  logic        rnd_done = 1'b0;

  // Reference: {err, result} from the opcode rules.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] s);
    logic [4:0]  sh;
    logic [31:0] r;
    sh = b[4:0];
    case (s)
      SLL: begin r = a << sh; return {1'b0, r}; end
      SRL: begin r = a >> sh; return {1'b0, r}; end
      SRA: begin r = $signed(a) >>> sh; return {1'b0, r}; end
`ifdef SHIFTER_ROT_EN
      ROTR: begin
        logic [63:0] dbl;
        dbl = {a, a} >> sh;
        return {1'b0, dbl[31:0]};
      end
`endif
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 4))
      0: return SLL;
      1: return SRL;
      2: return SRA;
      3: return ROTR;
      default: return 6'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
      ov_run = 0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
    end else begin
      if (stall_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(dataOut), 64'(held_d));
        check("hold_err", 64'(err), 64'(held_e));
      end
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL spurious_out: got result %h, expected no output (t=%0t)", dataOut, $time);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 64'(dataOut), 64'(e[31:0]));
            check("out_err", 64'(err), 64'(e[32]));
            got_q.push_back(dataOut);
          end
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          held_d = dataOut;
          held_e = err;
        end
        ov_run++;
        if (ov_run > ov_best) ov_best = ov_run;
      end else begin
        stall_prev = 1'b0;
        ov_run = 0;
      end
      if (in_valid && in_ready) exp_q.push_back(model(dataA, dataB, Signal));
      if (!in_ready) saw_block = 1'b1;
    end
  end

  // Single operation into an empty pipeline with out_ready high; checks the
  // exact two-cycle latency and the result. Starts and ends mid-cycle.
  task automatic run1(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] s, input logic [31:0] ed, input logic ee);
    @(posedge clk); #1;
    dataA = a; dataB = b; Signal = s; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dataA = $urandom; dataB = $urandom; Signal = 6'($urandom);
    @(negedge clk);
    check({nm, "_lat"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({nm, "_valid"}, 64'(out_valid), 64'd1);
    check({nm, "_data"}, 64'(dataOut), 64'(ed));
    check({nm, "_err"}, 64'(err), 64'(ee));
  endtask

  task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b,
                      input logic [5:0] s, input logic [7:0] ed, input logic ee);
    @(posedge clk); #1;
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(negedge clk);
    check({nm, "_lat"}, 64'(ov8), 64'd0);
    @(negedge clk);
    check({nm, "_valid"}, 64'(ov8), 64'd1);
    check({nm, "_data"}, 64'(d8), 64'(ed));
    check({nm, "_err"}, 64'(e8), 64'(ee));
  endtask

  // Present one operation and hold it until accepted. Call mid-cycle after a
  // rising edge; returns mid-cycle after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [5:0] s);
    int   t;
    logic acc;
    t = 0;
    dataA = a; dataB = b; Signal = s; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", t);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three cycles.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_dataOut", 64'(dataOut), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Hand-computed pins on the model itself.
    check("model_sll", 64'(model(32'h1, 32'd31, SLL)), 64'({1'b0, 32'h8000_0000}));
    check("model_sra", 64'(model(32'h8000_00F0, 32'd4, SRA)), 64'({1'b0, 32'hF800_000F}));
    check("model_srl", 64'(model(32'h8000_00F0, 32'h24, SRL)), 64'({1'b0, 32'h0800_000F}));

    // Basic and directed results.
    run1("sll31", 32'h0000_0001, 32'd31, SLL, 32'h8000_0000, 1'b0);
    run1("sra4", 32'h8000_00F0, 32'd4, SRA, 32'hF800_000F, 1'b0);
    run1("srl4", 32'h8000_00F0, 32'd4, SRL, 32'h0800_000F, 1'b0);
    run1("sra24", 32'h8000_00F0, 32'h24, SRA, 32'hF800_000F, 1'b0);
    run1("srl24", 32'h8000_00F0, 32'h24, SRL, 32'h0800_000F, 1'b0);
    run1("sll0", 32'hA5A5_1234, 32'h20, SLL, 32'hA5A5_1234, 1'b0);
    run1("sra0", 32'h8000_00F0, 32'h40, SRA, 32'h8000_00F0, 1'b0);
`ifdef SHIFTER_ROT_EN
    run1("rotr4", 32'h0000_00F1, 32'd4, ROTR, 32'h1000_000F, 1'b0);
    run1("rotr31", 32'h0000_0003, 32'd31, ROTR, 32'h0000_0006, 1'b0);
`else
    run1("rotr_off", 32'h0000_00F1, 32'd4, ROTR, 32'h0000_0000, 1'b1);
`endif
    run1("badop", 32'hFFFF_FFFF, 32'd1, 6'b111111, 32'h0000_0000, 1'b1);
    run1("sll_after_bad", 32'h0000_0003, 32'd1, SLL, 32'h0000_0006, 1'b0);

    // Backpressure: four SLLs of 1 by 0..3 with out_ready low for a while.
    @(posedge clk); #1;
    got_q.delete();
    saw_block = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(32'h1, 32'(i), SLL);
      end
      begin
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("bp_in_ready_drop", 64'(saw_block), 64'd1);
    check("bp_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("bp_order", (i < got_q.size()) ? 64'(got_q[i]) : 64'hDEAD, 64'(32'h1 << i));

    // Full throughput: 16 back-to-back random operations.
    ov_best = 0;
    for (int i = 0; i < 16; i++) send($urandom, $urandom, pick_op());
    repeat (4) @(posedge clk);
    #1;
    check("thru_run", 64'(ov_best), 64'd16);
    check("thru_drained", 64'(exp_q.size()), 64'd0);

    // Random traffic with random gaps and random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send($urandom, $urandom, pick_op());
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // Mid-flight reset with both stages full.
    out_ready = 1'b0;
    send(32'h1234_5678, 32'd3, SRL);
    send(32'h8765_4321, 32'd5, SRA);
    @(negedge clk);
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    #1 reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_idle", 64'(out_valid), 64'd0);
    end
    run1("post_rst_sll", 32'h0000_0001, 32'd4, SLL, 32'h0000_0010, 1'b0);

    // 8-bit instance.
    run8("w8_sra", 8'h90, 8'd3, SRA, 8'hF2, 1'b0);
    run8("w8_srl", 8'h90, 8'd3, SRL, 8'h12, 1'b0);
    run8("w8_sll", 8'h01, 8'd7, SLL, 8'h80, 1'b0);
    run8("w8_mask", 8'h90, 8'h0B, SRA, 8'hF2, 1'b0);
    run8("w8_bad", 8'h90, 8'd1, 6'b111111, 8'h00, 1'b1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
